hdmi_period_scheduler: RTL and testbench



---
 rtl/hdmi_period_scheduler_pkg.sv | 36 +++
 rtl/hdmi_period_scheduler_delay.sv | 28 ++
 rtl/hdmi_period_scheduler.sv | 179 +++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_period_scheduler_pkg.sv
// hdmi_pkg: shared types and constants for the HDMI period scheduler.
//   sched_state_t  : scheduler FSM state (control / preamble / guard band / active).
//   vid_beat_t     : one pixel-clock beat of the clocked-video stream.
//   VID_PREAMBLE_* : CTL codes driven on green/red lanes during the video preamble.
//   GB_*           : 10-bit video leading guard-band symbols. The downstream TMDS
//                    mux substitutes these for the encoder outputs while out_gb=1.
//   gate_pixel()   : forces pixel data to zero outside active video.
package hdmi_pkg;

  typedef enum logic [1:0] {
    ST_CTRL   = 2'd0,
    ST_PRE    = 2'd1,
    ST_GB     = 2'd2,
    ST_ACTIVE = 2'd3
  } sched_state_t;

  // Video preamble: CTL0..3 = 1,0,0,0 -> green {CTL1,CTL0}=01, red {CTL3,CTL2}=00
  localparam logic [1:0] VID_PREAMBLE_G = 2'b01;
  localparam logic [1:0] VID_PREAMBLE_R = 2'b00;

  localparam logic [9:0] GB_B = 10'b1011001100;
  localparam logic [9:0] GB_G = 10'b0100110011;
  localparam logic [9:0] GB_R = 10'b1011001100;

  typedef struct packed {
    logic [23:0] data;
    logic        de;
    logic        hsync;
    logic        vsync;
  } vid_beat_t;

  function automatic logic [23:0] gate_pixel(input logic de, input logic [23:0] d);
    return de ? d : 24'h0;
  endfunction

endpackage

// File: rtl/hdmi_period_scheduler_delay.sv
// video_delay_line: LEAD-deep register pipeline for the clocked-video beat
// {data, de, hsync, vsync}. A beat written at edge t is presented on dout
// after edge t+LEAD-1; the caller adds one output register on top.
//   clk   : pixel clock
//   reset : synchronous, active-high; clears every stage
//   din   : incoming beat
//   dout  : beat from the last stage
module video_delay_line
  import hdmi_pkg::*;
#(
  parameter int LEAD = 10
) (
  input  logic      clk,
  input  logic      reset,
  input  vid_beat_t din,
  output vid_beat_t dout
);

  vid_beat_t [LEAD-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[LEAD-2:0], din};
  end

  assign dout = pipe[LEAD-1];

endmodule

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: turns a DVI-style clocked-video stream into an
// HDMI-compliant one by inserting an 8-cycle video preamble and a 2-cycle
// leading guard band ahead of each active line. The video path is delayed by
// LEAD cycles so the inserted periods land in the blanking just before DE.
//
// Build option: define HDMI_PERIOD_SCHED_HDMI_EN for full scheduling. Without
// it the block is a plain LEAD-cycle delay (DVI mode) with out_cd_g, out_cd_r,
// out_gb and short_blank_err tied low; latency is the same in both builds.
//
// Ports:
//   clk, reset       : pixel clock, synchronous active-high reset
//   in_data/de/hsync/vsync : source video
//   clear_err        : one-cycle pulse clearing short_blank_err (a set wins)
//   out_vd           : pixel to encoders, zero outside active video
//   out_de           : VDE (delayed in_de)
//   out_cd_b         : {vsync, hsync}, delayed, always
//   out_cd_g/out_cd_r: CTL codes, preamble code during the preamble
//   out_gb           : guard-band override for the downstream symbol mux
//   short_blank_err  : sticky, blanking was too short to insert the preamble
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int LEAD      = 10,
  parameter int PRE_LEN   = 8,
  parameter int GB_LEN    = 2,
  parameter int MIN_BLANK = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_data,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        clear_err,
  output logic [23:0] out_vd,
  output logic        out_de,
  output logic [1:0]  out_cd_b,
  output logic [1:0]  out_cd_g,
  output logic [1:0]  out_cd_r,
  output logic        out_gb,
  output logic        short_blank_err
);

  vid_beat_t dl_in, dl_out;

  assign dl_in = '{data: in_data, de: in_de, hsync: in_hsync, vsync: in_vsync};

  video_delay_line #(.LEAD(LEAD)) u_dly (
    .clk  (clk),
    .reset(reset),
    .din  (dl_in),
    .dout (dl_out)
  );

  // Output stage for the video path: completes the LEAD-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vd   <= '0;
      out_de   <= 1'b0;
      out_cd_b <= '0;
    end else begin
      out_vd   <= gate_pixel(dl_out.de, dl_out.data);
      out_de   <= dl_out.de;
      out_cd_b <= {dl_out.vsync, dl_out.hsync};
    end
  end

`ifdef HDMI_PERIOD_SCHED_HDMI_EN

  localparam int BW = $clog2(MIN_BLANK + 1);
  localparam int PW = $clog2((PRE_LEN > GB_LEN) ? PRE_LEN : GB_LEN);

  logic [BW-1:0] blank_cnt;
  logic [PW-1:0] ph;
  sched_state_t  state;
  logic          de_rise, blank_short, de_fall, rise_err;

  // A non-zero blank count means the previous input cycle had DE low, so this
  // also treats a line already in progress when reset releases as no rise.
  assign de_rise     = in_de && (blank_cnt != '0);
  assign blank_short = blank_cnt < BW'(MIN_BLANK);
  // Delayed DE falling: the last active pixel of the line has just left.
  assign de_fall     = out_de && !dl_out.de;
  // A rise inside PRE/GB means the blanking was shorter than LEAD.
  assign rise_err    = de_rise && (blank_short || state == ST_PRE || state == ST_GB);

  always_ff @(posedge clk) begin
    if (reset)                             blank_cnt <= '0;
    else if (in_de)                        blank_cnt <= '0;
    else if (blank_cnt != BW'(MIN_BLANK))  blank_cnt <= blank_cnt + 1'b1;
  end

  // The decision taken on the input-side rise at edge t is registered at the
  // same edge, so the preamble occupies output cycles t..t+PRE_LEN-1 and the
  // guard band the GB_LEN cycles after it, ending exactly where delayed DE
  // (t+LEAD) begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_CTRL;
      ph              <= '0;
      out_cd_g        <= '0;
      out_cd_r        <= '0;
      out_gb          <= 1'b0;
      short_blank_err <= 1'b0;
    end else begin
      case (state)
        ST_CTRL: begin
          if (de_rise) begin
            if (!blank_short) begin
              state    <= ST_PRE;
              ph       <= '0;
              out_cd_g <= VID_PREAMBLE_G;
              out_cd_r <= VID_PREAMBLE_R;
            end else begin
              state    <= ST_ACTIVE;
              out_cd_g <= '0;
              out_cd_r <= '0;
            end
          end
        end
        ST_PRE: begin
          if (de_rise) begin
            state    <= ST_ACTIVE;
            out_cd_g <= '0;
            out_cd_r <= '0;
          end else if (ph == PW'(PRE_LEN - 1)) begin
            state    <= ST_GB;
            ph       <= '0;
            out_cd_g <= '0;
            out_cd_r <= '0;
            out_gb   <= 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_GB: begin
          if (de_rise) begin
            state  <= ST_ACTIVE;
            out_gb <= 1'b0;
          end else if (ph == PW'(GB_LEN - 1)) begin
            state  <= ST_ACTIVE;
            out_gb <= 1'b0;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_ACTIVE: begin
          // A new rise (short blank) keeps the line alive; otherwise leave
          // once the delayed line has drained.
          if (!de_rise && de_fall) state <= ST_CTRL;
        end
        default: begin
          state    <= ST_CTRL;
          out_cd_g <= '0;
          out_cd_r <= '0;
          out_gb   <= 1'b0;
        end
      endcase

      if (rise_err)       short_blank_err <= 1'b1;
      else if (clear_err) short_blank_err <= 1'b0;
    end
  end

`else

  // DVI mode: no period insertion, only the delay.
  localparam int unused_cfg = PRE_LEN + GB_LEN + MIN_BLANK;
  logic unused_clear;

  assign unused_clear    = clear_err;
  assign out_cd_g        = '0;
  assign out_cd_r        = '0;
  assign out_gb          = 1'b0;
  assign short_blank_err = 1'b0;

`endif

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
module tb_hdmi_period_scheduler;

  logic        clk = 1'b0;
  logic        reset, in_de, in_hsync, in_vsync, clear_err;
  logic [23:0] in_data;
  logic [23:0] out_vd;
  logic        out_de, out_gb, short_blank_err;
  logic [1:0]  out_cd_b, out_cd_g, out_cd_r;

  always #5 clk = ~clk;

  hdmi_period_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_de          (in_de),
    .in_hsync       (in_hsync),
    .in_vsync       (in_vsync),
    .clear_err      (clear_err),
    .out_vd         (out_vd),
    .out_de         (out_de),
    .out_cd_b       (out_cd_b),
    .out_cd_g       (out_cd_g),
    .out_cd_r       (out_cd_r),
    .out_gb         (out_gb),
    .short_blank_err(short_blank_err)
  );

`ifdef HDMI_PERIOD_SCHED_HDMI_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif

  // Stimulus segment: len cycles of constant inputs.
  typedef struct {
    int          len;
    logic        rst, de, hs, vs, clr;
    logic [23:0] data;
  } seg_t;

  // Expected outputs for output cycles lo..hi (HDMI-build values; the DVI
  // build expects cd_g, gb and err low throughout).
  typedef struct {
    int          lo, hi;
    logic        de;
    logic [23:0] vd;
    logic [1:0]  cdb, cdg;
    logic        gb, err;
  } win_t;

  seg_t segs[$];
  win_t wins[$];
  int   tests = 0;
  int   fails = 0;

  function automatic seg_t mk_seg(int len, logic rst, logic de, logic hs, logic vs,
                                  logic clr, logic [23:0] d);
    seg_t s;
    s.len = len; s.rst = rst; s.de = de; s.hs = hs; s.vs = vs; s.clr = clr; s.data = d;
    return s;
  endfunction

  function automatic win_t mk_win(int lo, int hi, logic de, logic [23:0] vd,
                                  logic [1:0] cdb, logic [1:0] cdg, logic gb, logic err);
    win_t w;
    w.lo = lo; w.hi = hi; w.de = de; w.vd = vd; w.cdb = cdb; w.cdg = cdg; w.gb = gb; w.err = err;
    return w;
  endfunction

  task automatic check_cycle(input int cyc);
    logic [1:0] e_cdg;
    logic       e_gb, e_err;
    foreach (wins[i]) begin
      if (cyc >= wins[i].lo && cyc <= wins[i].hi) begin
        e_cdg = HDMI ? wins[i].cdg : 2'b00;
        e_gb  = HDMI ? wins[i].gb  : 1'b0;
        e_err = HDMI ? wins[i].err : 1'b0;
        tests++;
        if ({out_de, out_vd, out_cd_b, out_cd_g, out_cd_r, out_gb, short_blank_err} !==
            {wins[i].de, wins[i].vd, wins[i].cdb, e_cdg, 2'b00, e_gb, e_err}) begin
          fails++;
          $display("FAIL window cyc %0d: got de=%b vd=%h cd_b=%b cd_g=%b cd_r=%b gb=%b err=%b ; want de=%b vd=%h cd_b=%b cd_g=%b cd_r=00 gb=%b err=%b",
                   cyc, out_de, out_vd, out_cd_b, out_cd_g, out_cd_r, out_gb, short_blank_err,
                   wins[i].de, wins[i].vd, wins[i].cdb, e_cdg, e_gb, e_err);
        end
      end
    end
  endtask

  initial begin
    int          cyc;
    int          lat;
    logic [1:0]  first_cdg;
    logic [23:0] lat_vd;

    reset = 1'b1; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    clear_err = 1'b0; in_data = '0;

    // ---- stimulus, cycle numbers in comments are the first edge of each segment
    segs.push_back(mk_seg( 2, 1, 0, 0, 0, 0, 24'h0));      //   0 reset
    segs.push_back(mk_seg(92, 0, 0, 0, 0, 0, 24'h0));      //   2 long blank
    segs.push_back(mk_seg( 3, 0, 0, 1, 0, 0, 24'h0));      //  94 hsync pulse
    segs.push_back(mk_seg( 1, 0, 0, 0, 0, 0, 24'h0));      //  97
    segs.push_back(mk_seg( 2, 0, 0, 0, 1, 0, 24'h0));      //  98 vsync pulse
    segs.push_back(mk_seg( 2, 0, 0, 0, 0, 0, 24'h0));      // 100
    segs.push_back(mk_seg(16, 0, 1, 0, 0, 0, 24'hA5A5A5)); // 102 line 1
    segs.push_back(mk_seg(11, 0, 0, 0, 0, 0, 24'h0));      // 118 11-cycle blank
    segs.push_back(mk_seg( 8, 0, 1, 0, 0, 0, 24'h123456)); // 129 short-blank line
    segs.push_back(mk_seg( 3, 0, 0, 0, 0, 0, 24'h0));      // 137
    segs.push_back(mk_seg( 1, 0, 0, 0, 0, 1, 24'h0));      // 140 clear, no rise
    segs.push_back(mk_seg( 6, 0, 0, 0, 0, 0, 24'h0));      // 141
    segs.push_back(mk_seg( 1, 0, 1, 0, 0, 1, 24'h0F0F0F)); // 147 clear on short rise
    segs.push_back(mk_seg( 3, 0, 1, 0, 0, 0, 24'h0F0F0F)); // 148
    segs.push_back(mk_seg(20, 0, 0, 0, 0, 0, 24'h0));      // 151
    segs.push_back(mk_seg( 3, 0, 1, 0, 0, 0, 24'h3C3C3C)); // 171 preamble starts
    segs.push_back(mk_seg( 1, 1, 1, 0, 0, 0, 24'h3C3C3C)); // 174 reset, 4th preamble
    segs.push_back(mk_seg( 6, 0, 1, 0, 0, 0, 24'h3C3C3C)); // 175 line continues
    segs.push_back(mk_seg(19, 0, 0, 0, 0, 0, 24'h0));      // 181
    segs.push_back(mk_seg(16, 0, 1, 0, 0, 0, 24'hC3C3C3)); // 200 full preamble again
    segs.push_back(mk_seg(24, 0, 0, 0, 0, 0, 24'h0));      // 216
    segs.push_back(mk_seg( 1, 0, 1, 0, 0, 0, 24'h111111)); // 240 1-pixel line
    segs.push_back(mk_seg( 3, 0, 0, 0, 0, 0, 24'h0));      // 241
    segs.push_back(mk_seg( 4, 0, 1, 0, 0, 0, 24'h222222)); // 244 rise inside PRE
    segs.push_back(mk_seg(18, 0, 0, 0, 0, 0, 24'h0));      // 248

    // ---- expected outputs, hand-derived from a 10-cycle lead
    wins.push_back(mk_win(  0,   1, 0, 24'h0,      2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(  2, 101, 0, 24'h0,      2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(102, 103, 0, 24'h0,      2'b00, 2'b01, 0, 0));
    wins.push_back(mk_win(104, 106, 0, 24'h0,      2'b01, 2'b01, 0, 0));
    wins.push_back(mk_win(107, 107, 0, 24'h0,      2'b00, 2'b01, 0, 0));
    wins.push_back(mk_win(108, 109, 0, 24'h0,      2'b10, 2'b01, 0, 0));
    wins.push_back(mk_win(110, 111, 0, 24'h0,      2'b00, 2'b00, 1, 0));
    wins.push_back(mk_win(112, 127, 1, 24'hA5A5A5, 2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(128, 128, 0, 24'h0,      2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(129, 138, 0, 24'h0,      2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(139, 139, 1, 24'h123456, 2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(140, 146, 1, 24'h123456, 2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(147, 156, 0, 24'h0,      2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(157, 160, 1, 24'h0F0F0F, 2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(161, 170, 0, 24'h0,      2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(171, 173, 0, 24'h0,      2'b00, 2'b01, 0, 1));
    wins.push_back(mk_win(174, 184, 0, 24'h0,      2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(185, 190, 1, 24'h3C3C3C, 2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(191, 199, 0, 24'h0,      2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(200, 207, 0, 24'h0,      2'b00, 2'b01, 0, 0));
    wins.push_back(mk_win(208, 209, 0, 24'h0,      2'b00, 2'b00, 1, 0));
    wins.push_back(mk_win(210, 225, 1, 24'hC3C3C3, 2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(226, 239, 0, 24'h0,      2'b00, 2'b00, 0, 0));
    wins.push_back(mk_win(240, 243, 0, 24'h0,      2'b00, 2'b01, 0, 0));
    wins.push_back(mk_win(244, 249, 0, 24'h0,      2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(250, 250, 1, 24'h111111, 2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(251, 253, 0, 24'h0,      2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(254, 257, 1, 24'h222222, 2'b00, 2'b00, 0, 1));
    wins.push_back(mk_win(258, 265, 0, 24'h0,      2'b00, 2'b00, 0, 1));

    @(negedge clk);
    cyc = 0;
    foreach (segs[i]) begin
      for (int n = 0; n < segs[i].len; n++) begin
        reset = segs[i].rst; in_de = segs[i].de; in_hsync = segs[i].hs;
        in_vsync = segs[i].vs; clear_err = segs[i].clr; in_data = segs[i].data;
        @(posedge clk);
        @(negedge clk);
        check_cycle(cyc);
        cyc++;
      end
    end

    // ---- hand-written: single-pixel line after a long blank, measure latency
    reset = 1'b0; clear_err = 1'b0; in_de = 1'b1; in_data = 24'hABCDEF;
    @(posedge clk);
    @(negedge clk);
    first_cdg = out_cd_g;
    in_de = 1'b0; in_data = '0;
    lat = 0; lat_vd = '0;
    while (!out_de && lat < 30) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      lat_vd = out_vd;
    end
    tests++;
    if (lat != 10) begin
      fails++;
      $display("FAIL latency: got %0d cycles, want 10", lat);
    end
    tests++;
    if (lat_vd !== 24'hABCDEF) begin
      fails++;
      $display("FAIL latency_pixel: got %h, want abcdef", lat_vd);
    end
    tests++;
    if (first_cdg !== (HDMI ? 2'b01 : 2'b00)) begin
      fails++;
      $display("FAIL preamble_first: got cd_g=%b, want %b", first_cdg, HDMI ? 2'b01 : 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
